cond_unit: RTL and testbench
============================

# cond_unit

Condition unit sitting directly downstream of the ALU in the single-cycle ARM datapath. Holds the architectural NZCV flag register, evaluates the instruction's 4-bit condition field against the stored flags, and gates the decoder's PC, register and memory write strobes so that failed-condition instructions have no architectural effect. Also keeps executed/skipped instruction counters for bring-up and performance debug.

## Interface
Parameters:
- CNT_W, 32, width of the executed/skipped counters

Ports:
- clk  in  1  processor clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- InstrValid  in  1  current instruction is real (0 during fetch bubble or halt); gates all state updates
- Cond  in  4  instruction bits [31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  in  2  bit1: write N,Z; bit0: write C,V (from decoder)
- PCS  in  1  instruction writes PC
- RegW  in  1  instruction writes register file
- MemW  in  1  instruction writes memory
- NoWrite  in  1  compare-type instruction (CMP/CMN/TST): suppress register write
- CntClear  in  1  synchronous clear of both counters
- PCSrc  out  1  gated PC-write strobe
- RegWrite  out  1  gated register-write strobe
- MemWrite  out  1  gated memory-write strobe
- CondEx  out  1  condition passed for current instruction
- Flags  out  4  registered {N,Z,C,V}
- ExecCount  out  CNT_W  instructions with InstrValid=1 and CondEx=1
- SkipCount  out  CNT_W  instructions with InstrValid=1 and CondEx=0

## Operation
- CondEx is combinational from Cond and the registered Flags (never from ALUFlags of the same instruction):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 treated as unconditional, CondEx=1
- Gated strobes (all combinational): PCSrc = PCS&CondEx&InstrValid; RegWrite = RegW&~NoWrite&CondEx&InstrValid; MemWrite = MemW&CondEx&InstrValid.
- Flag update at rising edge when InstrValid&CondEx: FlagW[1] loads N,Z from ALUFlags[3:2]; FlagW[0] loads C,V from ALUFlags[1:0]; the halves are independent. Otherwise Flags hold.
- Counters: on InstrValid, exactly one of ExecCount/SkipCount increments by 1; both wrap modulo 2^CNT_W. CntClear takes priority over increment: both become 0 and the current instruction is not counted. CntClear does not touch Flags.

## Timing
- Reset: Flags=4'b0000, ExecCount=0, SkipCount=0. With Flags=0 combinational outputs follow inputs immediately (e.g. EQ fails, NE passes).
- Zero-cycle latency for CondEx and gated strobes; one-cycle latency for Flags (new flags visible to the next instruction's condition).
- Same-cycle flag-setting and condition test (e.g. ADDSEQ): condition uses old flags; flags update only if the old flags pass.
- reset asserted with any other input: reset wins; no flag or counter update that cycle.
- InstrValid=0: all strobes 0, Flags and counters hold, CondEx still reflects Cond vs Flags.
- Counter at all-ones plus increment: wraps to 0, other counter unaffected.

## Structure
- Shared package (cpu_pkg): cond_e enum of the 16 condition encodings; flag bit-index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
- One sub-module: cond_check, purely combinational (Cond, Flags) -> CondEx; reused by any future branch-predict or pipeline hazard logic. Flag register, gating and counters live in cond_unit.

## Test plan
- Reset then Cond=0000, InstrValid=1, RegW=1 -> CondEx=0, RegWrite=0, SkipCount=1 next cycle; Cond=0001 -> CondEx=1, RegWrite=1.
- CMP (FlagW=11, NoWrite=1, RegW=1, Cond=1110) with ALUFlags=0100 -> RegWrite=0; next cycle Flags=0100, Cond=0000 BEQ with PCS=1 -> PCSrc=1.
- Partial update: Flags=1111, FlagW=10, ALUFlags=0000, Cond=1110 -> Flags=0011; FlagW=01 with ALUFlags=0000 -> Flags=0000.
- Same-cycle ADDSEQ: Flags=0000, Cond=0000, FlagW=11, ALUFlags=0100 -> CondEx=0, Flags stay 0000, SkipCount increments.
- Sweep all 16 Cond values against all 16 Flags values -> CondEx matches table; GE/LT/GT/LE checked with N=1,V=1 and N=1,V=0.
- CNT_W=4: 15 executed instructions then one more -> ExecCount 15 then 0; CntClear with InstrValid=1 -> both counters 0, no count; InstrValid=0 with PCS=MemW=1 -> PCSrc=MemWrite=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath definitions.
//   cond_e : the 16 ARM condition-field encodings (instruction bits [31:28])
//   *_IDX  : bit positions of N, Z, C and V inside a 4-bit {N,Z,C,V} flag word
package cpu_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: tests a 4-bit condition field against
// a {N,Z,C,V} flag word. Kept separate so branch-predict or hazard logic can
// reuse it.
//   cond    in  4  condition field
//   flags   in  4  {N,Z,C,V}
//   cond_ex out 1  condition passed
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v;

   assign n = flags[N_IDX];
   assign z = flags[Z_IDX];
   assign c = flags[C_IDX];
   assign v = flags[V_IDX];

   always_comb begin
      cond_ex = 1'b1;
      case (cond_e'(cond))
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         // 1111 is executed unconditionally rather than as "never".
         COND_NV: cond_ex = 1'b1;
         default: cond_ex = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Condition unit downstream of the ALU. Holds the NZCV flag register,
// evaluates the condition field against the stored flags, gates the
// decoder's write strobes and counts executed/skipped instructions.
//   clk, reset            clock, synchronous active-high reset
//   InstrValid            instruction is real; gates all state updates
//   Cond, ALUFlags, FlagW condition field, ALU {N,Z,C,V}, flag-write enables
//   PCS, RegW, MemW       ungated write strobes from the decoder
//   NoWrite               compare-type instruction, suppress register write
//   CntClear              synchronous clear of both counters
//   PCSrc, RegWrite,
//   MemWrite              gated strobes
//   CondEx                condition passed
//   Flags                 registered {N,Z,C,V}
//   ExecCount, SkipCount  executed / skipped instruction counters
module cond_unit
   import cpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InstrValid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   input  logic             CntClear,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] ExecCount,
   output logic [CNT_W-1:0] SkipCount
);

   logic commit;

   // Evaluated against the registered flags, so a flag-setting conditional
   // instruction sees the flags left by its predecessor.
   cond_check u_cond_check (
      .cond    (Cond),
      .flags   (Flags),
      .cond_ex (CondEx)
   );

   assign commit   = CondEx & InstrValid;
   assign PCSrc    = PCS & commit;
   assign RegWrite = RegW & ~NoWrite & commit;
   assign MemWrite = MemW & commit;

   always_ff @(posedge clk) begin
      if (reset) begin
         Flags <= 4'b0000;
      end else if (commit) begin
         if (FlagW[1]) begin
            Flags[N_IDX] <= ALUFlags[N_IDX];
            Flags[Z_IDX] <= ALUFlags[Z_IDX];
         end
         if (FlagW[0]) begin
            Flags[C_IDX] <= ALUFlags[C_IDX];
            Flags[V_IDX] <= ALUFlags[V_IDX];
         end
      end
   end

   // Clear beats increment: the instruction in the clearing cycle is dropped.
   always_ff @(posedge clk) begin
      if (reset || CntClear) begin
         ExecCount <= '0;
         SkipCount <= '0;
      end else if (InstrValid) begin
         if (CondEx) ExecCount <= ExecCount + CNT_W'(1);
         else        SkipCount <= SkipCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit, built with 4-bit counters to reach wrap.
module tb_cond_unit;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          InstrValid;
   logic [3:0]    Cond;
   logic [3:0]    ALUFlags;
   logic [1:0]    FlagW;
   logic          PCS, RegW, MemW, NoWrite, CntClear;
   logic          PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0]    Flags;
   logic [CW-1:0] ExecCount, SkipCount;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cond_unit #(.CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .InstrValid (InstrValid),
      .Cond       (Cond),
      .ALUFlags   (ALUFlags),
      .FlagW      (FlagW),
      .PCS        (PCS),
      .RegW       (RegW),
      .MemW       (MemW),
      .NoWrite    (NoWrite),
      .CntClear   (CntClear),
      .PCSrc      (PCSrc),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .CondEx     (CondEx),
      .Flags      (Flags),
      .ExecCount  (ExecCount),
      .SkipCount  (SkipCount)
   );

   // Reference: base test for each even/odd condition pair, odd code inverts.
   function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      if (c[3:1] == 3'b111) return 1'b1;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n ~^ v);
         3'd6: base = !z && (n ~^ v);
         default: base = 1'b0;
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; InstrValid = 0; Cond = 4'he; ALUFlags = 0; FlagW = 0;
      PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; CntClear = 0;
   endtask

   task automatic load_flags(input logic [3:0] f);
      idle();
      InstrValid = 1; Cond = 4'he; FlagW = 2'b11; ALUFlags = f;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      reset = 1; InstrValid = 1; Cond = 4'he; FlagW = 2'b11; ALUFlags = 4'hf;
      tick();
      tick();
      checks++;
      if (Flags !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got=%b exp=0000", Flags);
      end
      checks++;
      if (ExecCount !== '0 || SkipCount !== '0) begin
         errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", ExecCount, SkipCount);
      end
      idle();
   endtask

   task automatic test_eq_ne();
      idle();
      InstrValid = 1; RegW = 1; Cond = 4'b0000;
      #1;
      checks++;
      if (CondEx !== 1'b0 || RegWrite !== 1'b0) begin
         errors++; $display("FAIL eq_after_reset condex=%b regwrite=%b exp=0/0", CondEx, RegWrite);
      end
      tick();
      checks++;
      if (SkipCount !== 4'd1 || ExecCount !== 4'd0) begin
         errors++; $display("FAIL eq_skip got=%0d/%0d exp exec=0 skip=1", ExecCount, SkipCount);
      end
      Cond = 4'b0001;
      #1;
      checks++;
      if (CondEx !== 1'b1 || RegWrite !== 1'b1) begin
         errors++; $display("FAIL ne_after_reset condex=%b regwrite=%b exp=1/1", CondEx, RegWrite);
      end
      tick();
      checks++;
      if (ExecCount !== 4'd1) begin
         errors++; $display("FAIL ne_exec got=%0d exp=1", ExecCount);
      end
      idle();
   endtask

   task automatic test_cmp_beq();
      idle();
      InstrValid = 1; Cond = 4'he; FlagW = 2'b11; NoWrite = 1; RegW = 1; ALUFlags = 4'b0100;
      #1;
      checks++;
      if (RegWrite !== 1'b0 || CondEx !== 1'b1) begin
         errors++; $display("FAIL cmp_regwrite regwrite=%b condex=%b exp=0/1", RegWrite, CondEx);
      end
      tick();
      checks++;
      if (Flags !== 4'b0100) begin
         errors++; $display("FAIL cmp_flags got=%b exp=0100", Flags);
      end
      idle();
      InstrValid = 1; Cond = 4'b0000; PCS = 1;
      #1;
      checks++;
      if (PCSrc !== 1'b1) begin
         errors++; $display("FAIL beq_pcsrc got=%b exp=1", PCSrc);
      end
      tick();
      idle();
   endtask

   task automatic test_partial();
      load_flags(4'b1111);
      checks++;
      if (Flags !== 4'b1111) begin
         errors++; $display("FAIL partial_load got=%b exp=1111", Flags);
      end
      InstrValid = 1; Cond = 4'he; FlagW = 2'b10; ALUFlags = 4'b0000;
      tick();
      checks++;
      if (Flags !== 4'b0011) begin
         errors++; $display("FAIL partial_nz got=%b exp=0011", Flags);
      end
      FlagW = 2'b01;
      tick();
      checks++;
      if (Flags !== 4'b0000) begin
         errors++; $display("FAIL partial_cv got=%b exp=0000", Flags);
      end
      idle();
   endtask

   task automatic test_addseq();
      idle();
      CntClear = 1;
      tick();
      idle();
      InstrValid = 1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1; MemW = 1;
      #1;
      checks++;
      if (CondEx !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
         errors++; $display("FAIL addseq_strobes condex=%b reg=%b mem=%b exp=0/0/0", CondEx, RegWrite, MemWrite);
      end
      tick();
      checks++;
      if (Flags !== 4'b0000 || SkipCount !== 4'd1 || ExecCount !== 4'd0) begin
         errors++; $display("FAIL addseq_state flags=%b skip=%0d exec=%0d exp=0000/1/0", Flags, SkipCount, ExecCount);
      end
      idle();
   endtask

   task automatic test_sweep();
      logic e;
      for (int f = 0; f < 16; f++) begin
         load_flags(4'(f));
         for (int c = 0; c < 16; c++) begin
            Cond = 4'(c);
            #1;
            e = exp_cond(4'(c), 4'(f));
            checks++;
            if (CondEx !== e) begin
               errors++; $display("FAIL sweep cond=%b flags=%b got=%b exp=%b", 4'(c), 4'(f), CondEx, e);
            end
         end
      end
      // N=1,V=1 (Z=0): GE,GT pass; LT,LE fail
      load_flags(4'b1001);
      Cond = 4'b1010; #1; checks++;
      if (CondEx !== 1'b1) begin errors++; $display("FAIL ge_n1v1 got=%b exp=1", CondEx); end
      Cond = 4'b1011; #1; checks++;
      if (CondEx !== 1'b0) begin errors++; $display("FAIL lt_n1v1 got=%b exp=0", CondEx); end
      Cond = 4'b1100; #1; checks++;
      if (CondEx !== 1'b1) begin errors++; $display("FAIL gt_n1v1 got=%b exp=1", CondEx); end
      Cond = 4'b1101; #1; checks++;
      if (CondEx !== 1'b0) begin errors++; $display("FAIL le_n1v1 got=%b exp=0", CondEx); end
      // N=1,V=0: opposite
      load_flags(4'b1000);
      Cond = 4'b1010; #1; checks++;
      if (CondEx !== 1'b0) begin errors++; $display("FAIL ge_n1v0 got=%b exp=0", CondEx); end
      Cond = 4'b1011; #1; checks++;
      if (CondEx !== 1'b1) begin errors++; $display("FAIL lt_n1v0 got=%b exp=1", CondEx); end
      Cond = 4'b1100; #1; checks++;
      if (CondEx !== 1'b0) begin errors++; $display("FAIL gt_n1v0 got=%b exp=0", CondEx); end
      Cond = 4'b1101; #1; checks++;
      if (CondEx !== 1'b1) begin errors++; $display("FAIL le_n1v0 got=%b exp=1", CondEx); end
      idle();
   endtask

   task automatic test_counters();
      idle();
      CntClear = 1;
      tick();
      idle();
      InstrValid = 1; Cond = 4'he;
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (ExecCount !== 4'd15 || SkipCount !== 4'd0) begin
         errors++; $display("FAIL exec_15 got=%0d/%0d exp=15/0", ExecCount, SkipCount);
      end
      tick();
      checks++;
      if (ExecCount !== 4'd0 || SkipCount !== 4'd0) begin
         errors++; $display("FAIL exec_wrap got=%0d/%0d exp=0/0", ExecCount, SkipCount);
      end
      tick();
      tick();
      Cond = 4'b0000;   // Z=0, fails
      tick();
      checks++;
      if (ExecCount !== 4'd2 || SkipCount !== 4'd1) begin
         errors++; $display("FAIL pre_clear got=%0d/%0d exp=2/1", ExecCount, SkipCount);
      end
      Cond = 4'he; CntClear = 1; FlagW = 2'b11; ALUFlags = 4'b1010;
      tick();
      checks++;
      if (ExecCount !== 4'd0 || SkipCount !== 4'd0) begin
         errors++; $display("FAIL clear_priority got=%0d/%0d exp=0/0", ExecCount, SkipCount);
      end
      checks++;
      if (Flags !== 4'b1010) begin
         errors++; $display("FAIL clear_flags got=%b exp=1010", Flags);
      end
      idle();
      PCS = 1; MemW = 1; RegW = 1; Cond = 4'he; FlagW = 2'b11; ALUFlags = 4'b0101;
      #1;
      checks++;
      if (PCSrc !== 1'b0 || MemWrite !== 1'b0 || RegWrite !== 1'b0 || CondEx !== 1'b1) begin
         errors++; $display("FAIL invalid_strobes pc=%b mem=%b reg=%b condex=%b exp=0/0/0/1", PCSrc, MemWrite, RegWrite, CondEx);
      end
      tick();
      checks++;
      if (Flags !== 4'b1010 || ExecCount !== 4'd0 || SkipCount !== 4'd0) begin
         errors++; $display("FAIL invalid_hold flags=%b exec=%0d skip=%0d exp=1010/0/0", Flags, ExecCount, SkipCount);
      end
      // reset wins over a committing instruction
      InstrValid = 1; reset = 1;
      tick();
      checks++;
      if (Flags !== 4'b0000 || ExecCount !== 4'd0) begin
         errors++; $display("FAIL reset_wins flags=%b exec=%0d exp=0000/0", Flags, ExecCount);
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_eq_ne();
      test_cmp_beq();
      test_partial();
      test_addseq();
      test_sweep();
      test_counters();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
